// File: rtl/dm_port_arbiter.sv
// Two-port arbiter sharing one data-memory port between the CPU (port 0) and a secondary master (port 1).
// Build option: define DM_ARB_RR_EN for round-robin tie-breaking; fixed priority to port 0 otherwise.
module dm_port_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data
);

  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            owner_r, owner_s;
  logic            last_owner_r, last_owner_s;
  logic [CW-1:0]   lock_cnt_r, lock_cnt_s;
  logic            we_r, we_s;
  logic            load_s;
  logic            any_req_s, req_own_s, lock_own_s, arb_win_s;
  logic            we_sel_s;
  logic [31:0]     addr_sel_s, wdata_sel_s;

`ifdef DM_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic lo);
    if (r0 && r1) begin
      return ~lo;
    end else if (r0) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction
`else
  function automatic logic arb_pick(input logic r0);
    if (r0) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction
`endif

  // Next-state, ownership, lock counter and request-latch selection.
  always_comb begin
    any_req_s    = req0 | req1;
    req_own_s    = owner_r ? req1 : req0;
    lock_own_s   = owner_r ? lock1 : lock0;
`ifdef DM_ARB_RR_EN
    arb_win_s    = arb_pick(req0, req1, last_owner_r);
`else
    arb_win_s    = arb_pick(req0);
`endif
    state_s      = state_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    lock_cnt_s   = lock_cnt_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          owner_s      = arb_win_s;
          last_owner_s = arb_win_s;
          load_s       = 1'b1;
          state_s      = ISSUE;
        end else begin
          state_s      = IDLE;
        end
      end
      ISSUE: begin
        state_s = RESP;
      end
      RESP: begin
        // A locked owner keeps the bus without arbitration until the bound is hit.
        if (lock_own_s && req_own_s && (lock_cnt_r < LOCK_LAST)) begin
          load_s       = 1'b1;
          lock_cnt_s   = lock_cnt_r + CW'(1);
          state_s      = ISSUE;
        end else if (any_req_s) begin
          owner_s      = arb_win_s;
          last_owner_s = arb_win_s;
          load_s       = 1'b1;
          lock_cnt_s   = '0;
          state_s      = ISSUE;
        end else begin
          lock_cnt_s   = '0;
          state_s      = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    we_sel_s    = owner_s ? we1 : we0;
    addr_sel_s  = owner_s ? addr1 : addr0;
    wdata_sel_s = owner_s ? wdata1 : wdata0;
    we_s        = load_s ? we_sel_s : we_r;
  end

  // State, latch and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      lock_cnt_r   <= '0;
      we_r         <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      Address      <= 32'h0000_0000;
      Write_data   <= 32'h0000_0000;
      rdata        <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
      lock_cnt_r   <= lock_cnt_s;
      we_r         <= we_s;
      gnt0         <= (state_s == ISSUE) && (owner_s == 1'b0);
      gnt1         <= (state_s == ISSUE) && (owner_s == 1'b1);
      ack0         <= (state_s == RESP) && (owner_s == 1'b0);
      ack1         <= (state_s == RESP) && (owner_s == 1'b1);
      MemRead      <= (state_s == ISSUE) && !we_s;
      MemWrite     <= (state_s == ISSUE) && we_s;
      if (load_s) begin
        Address    <= addr_sel_s;
        Write_data <= wdata_sel_s;
      end else begin
        Address    <= Address;
        Write_data <= Write_data;
      end
      // Memory read data is combinational, so capture it as the ISSUE cycle closes.
      if ((state_r == ISSUE) && !we_r) begin
        rdata <= Read_data;
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed testbench for dm_port_arbiter with a small word-addressed memory model.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, MemRead, MemWrite;
  logic [31:0] rdata, Address, Write_data, Read_data;
  logic [31:0] mem [0:255];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data)
  );

  assign Read_data = mem[Address[9:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[Address[9:2]] <= Write_data;
  end

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
  endtask

  task automatic test_reset();
    logic [102:0] outs;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    outs = {gnt0, gnt1, ack0, ack1, MemRead, MemWrite, Address, Write_data, rdata};
    vectors++;
    if (outs !== 103'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, MemRead, MemWrite} !== 4'b1010 || Address !== 32'h0) begin
      miscompares++;
      $display("FAIL read_issue: gnt0/gnt1/rd/wr=%b addr=%h want 1010 addr 0",
               {gnt0, gnt1, MemRead, MemWrite}, Address);
    end
    req0 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, gnt0, MemRead} !== 4'b1000 || rdata !== 32'h0000_003F) begin
      miscompares++;
      $display("FAIL read_resp: ack0/ack1/gnt0/rd=%b rdata=%h want 1000 rdata 3f",
               {ack0, ack1, gnt0, MemRead}, rdata);
    end
    @(negedge clk);
    vectors++;
    if (ack0 !== 1'b0 || rdata !== 32'h0000_003F) begin
      miscompares++;
      $display("FAIL read_hold: ack0=%b rdata=%h want 0 3f", ack0, rdata);
    end
  endtask

  task automatic test_single_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4000_0010; wdata1 = 32'h0000_1234;
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, MemRead, MemWrite} !== 4'b0101 || Address !== 32'h4000_0010 ||
        Write_data !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL write_issue: gnt0/gnt1/rd/wr=%b addr=%h wd=%h want 0101 40000010 1234",
               {gnt0, gnt1, MemRead, MemWrite}, Address, Write_data);
    end
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, MemWrite} !== 3'b010 || rdata !== 32'h0000_003F ||
        mem[4] !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL write_resp: ack0/ack1/wr=%b rdata=%h mem=%h want 010 3f 1234",
               {ack0, ack1, MemWrite}, rdata, mem[4]);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n = 0;
    logic [3:0] owners = 4'b0000;
    logic [3:0] exp_owners;
`ifdef DM_ARB_RR_EN
    exp_owners = 4'b1010;
`else
    exp_owners = 4'b0000;
`endif
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) begin
        vectors++; miscompares++;
        $display("FAIL contention_both_gnt: cycle %0d both grants high", i);
      end
      if ((gnt0 || gnt1) && n < 4) begin
        owners[n] = gnt1;
        vectors++;
        if (Address !== (gnt1 ? 32'h200 : 32'h100)) begin
          miscompares++;
          $display("FAIL contention_addr: grant %0d addr=%h", n, Address);
        end
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (n !== 4 || owners !== exp_owners) begin
      miscompares++;
      $display("FAIL contention_order: grants=%0d owners(lsb first)=%b want 4 %b",
               n, owners, exp_owners);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock_bound();
    int n = 0;
    logic [4:0] owners = 5'b00000;
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 32'h300;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req0 = 1'b1; addr0 = 32'h100;
      end
      if ((gnt0 || gnt1) && n < 5) begin
        owners[n] = gnt1;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    vectors++;
    if (n !== 5 || owners !== 5'b01111) begin
      miscompares++;
      $display("FAIL lock_bound: grants=%0d owners(lsb first)=%b want 5 01111", n, owners);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdrawn();
    int g0 = 0;
    int g1 = 0;
    int wr = 0;
    req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h50; wdata1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req1 = 1'b0; we1 = 1'b0;
      g0 += int'(gnt0);
      g1 += int'(gnt1);
      wr += int'(MemWrite);
    end
    req0 = 1'b0; lock0 = 1'b0;
    vectors++;
    if (g1 !== 0 || wr !== 0 || mem[20] !== 32'h0) begin
      miscompares++;
      $display("FAIL withdrawn_req1: gnt1=%0d writes=%0d mem=%h want 0 0 0", g1, wr, mem[20]);
    end
    vectors++;
    if (g0 !== 4) begin
      miscompares++;
      $display("FAIL withdrawn_port0: gnt0 count=%0d want 4", g0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    logic [102:0] outs;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hCAFE_F00D;
    @(negedge clk);
    vectors++;
    if (gnt0 !== 1'b1 || MemWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_write_issue: gnt0=%b wr=%b want 1 1", gnt0, MemWrite);
    end
    reset = 1'b0; req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    outs = {gnt0, gnt1, ack0, ack1, MemRead, MemWrite, Address, Write_data, rdata};
    vectors++;
    if (outs !== 103'd0 || mem[16] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL rst_mid_write: outs=%h mem=%h want 0 cafef00d", outs, mem[16]);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, ack0, ack1, MemRead, MemWrite} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_idle: strobes=%b want 0", {gnt0, gnt1, ack0, ack1, MemRead, MemWrite});
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    @(negedge clk);
    req0 = 1'b0;
    vectors++;
    if (gnt0 !== 1'b1 || MemRead !== 1'b1 || Address !== 32'h40) begin
      miscompares++;
      $display("FAIL rst_readback_issue: gnt0=%b rd=%b addr=%h want 1 1 40", gnt0, MemRead, Address);
    end
    @(negedge clk);
    vectors++;
    if (ack0 !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL rst_readback: ack0=%b rdata=%h want 1 cafef00d", ack0, rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_003F;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_lock_bound();
    test_withdrawn();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Two-requester arbiter that shares the single data-memory port between the MIPS core (port 0) and a secondary master such as a loader or debug engine (port 1). It sits between both masters and the data memory. It latches the winning request, drives `MemRead`/`MemWrite`/`Address`/`Write_data` for exactly one cycle, captures `Read_data`, and returns a one-cycle acknowledge to the owner. An optional lock lets one master perform back-to-back accesses up to a bounded count.

## Interface
- `MAX_LOCK`, 4: maximum consecutive locked accesses by one owner before forced re-arbitration (≥1).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising edge of `clk`.
- `req0`, `req1` input 1: access request from port 0 (CPU) / port 1.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `lock0`, `lock1` input 1: request to keep ownership after the current access.
- `addr0`, `addr1` input 32: byte address, passed to memory unchanged.
- `wdata0`, `wdata1` input 32: write data.
- `gnt0`, `gnt1` output 1: request accepted; high for the ISSUE cycle.
- `ack0`, `ack1` output 1: access complete; high for the RESP cycle.
- `rdata` output 32: captured read data, valid while `ack0`/`ack1` is high, held otherwise.
- `MemRead`, `MemWrite` output 1: memory strobes.
- `Address`, `Write_data` output 32: memory address and data.
- `Read_data` input 32: combinational read data from memory.

## Operation
- FSM states are IDLE, ISSUE and RESP. All outputs are registered.
- Reset (`reset`=0 at an edge):
  - state → IDLE.
  - `gnt*`, `ack*`, `MemRead`, `MemWrite` → 0.
  - `Address`, `Write_data`, `rdata` → 0.
  - `last_owner` → 1, so port 0 wins the first tie.
  - `lock_cnt` → 0.
- IDLE:
  - If any `req` is high, select the winner, latch its `we`/`addr`/`wdata`, set `owner`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `gnt[owner]`=1.
  - `MemWrite`=`we`, `MemRead`=!`we`, `Address`/`Write_data` come from the latch.
  - At the closing edge, `rdata` ← `Read_data` on reads only; writes leave `rdata` unchanged.
  - Always go to RESP.
- RESP:
  - `ack[owner]`=1; memory strobes are 0.
  - If `lock[owner]`, `req[owner]` and `lock_cnt` < `MAX_LOCK`-1 are all true: latch the owner's new request, `lock_cnt`++, go to ISSUE with no arbitration.
  - Else, if any `req` is high: arbitrate, `lock_cnt` ← 0, go to ISSUE.
  - Else: `lock_cnt` ← 0, go to IDLE.
- Requester rules:
  - Hold `req`/`we`/`addr`/`wdata` stable until `gnt` is seen.
  - After `gnt`, change them freely.
  - Deassert `req` on the `ack` cycle unless another access is wanted.
- A request withdrawn before `gnt` is never serviced.
- Simultaneous requests follow the arbitration rule under Configuration.
- Address decoding is not done here. Device-region addresses (bit 30 set) are issued identically.
- Reset asserted while in ISSUE: the memory still sees the strobe at that edge, so the write lands, but no `ack` follows.
- Reset asserted while in RESP: `ack` drops at the next edge.

## Timing
- Request sampled at edge E0 → `gnt` during E0–E1 → memory access completes at E1 → `ack` and valid `rdata` during E1–E2.
- Read latency is 2 cycles from the sampling edge.
- Throughput is one access per 2 cycles, both for locked back-to-back accesses and under continuous contention.
- `gnt0`&`gnt1` and `ack0`&`ack1` are never high together.
- `MemRead`&`MemWrite` are never high together.

## Configuration
- Macro: `DM_ARB_RR_EN`.
- Defined: round-robin arbitration. On a tie, the port ≠ `last_owner` wins; `last_owner` updates on each arbitration.
- Undefined: fixed priority. Port 0 always wins ties; `last_owner` is unused. Port 1 is served only when `req0`=0 at the arbitration edge, or while it holds a lock.
- The lock behaviour is identical in both builds.

## Test plan
- Single read:
  - Memory model returns 0x0000_003F at 0x0.
  - `req0`=1, `we0`=0, `addr0`=0x0.
  - Expect `gnt0` in the first cycle with `MemRead`=1 and `Address`=0x0.
  - Expect `ack0` in the second cycle with `rdata`=0x0000_003F.
- Single write:
  - Port 1 writes 0x1234 to 0x4000_0010.
  - Expect one cycle of `MemWrite`=1 with `Address`=0x4000_0010 and `Write_data`=0x1234, then `ack1`.
  - Expect `rdata` unchanged.
- Contention:
  - `req0` and `req1` held high with distinct addresses for 8 cycles.
  - With `DM_ARB_RR_EN`: grants go 0,1,0,1.
  - Without it: all four grants go to port 0.
- Lock bound:
  - `MAX_LOCK`=4; `lock1`=1, `req1` held high, `req0` high.
  - Expect 4 consecutive port-1 accesses, then `gnt0`, in both builds.
- Reset mid-write:
  - Drive `reset` low in the ISSUE cycle of a write to 0x40.
  - Expect the memory word at 0x40 updated, no `ack`, all outputs 0 after the edge, and state IDLE.
- Withdrawn request:
  - `req1` pulses for one cycle while port 0 owns the locked bus.
  - Expect no `gnt1` and no memory access by port 1.
